exposure_sequencer: RTL and testbench
=====================================

Name: exposure_sequencer

Overview:
- Sequences a full CCD exposure without host involvement: open shutter, wait for servo settle, time the exposure, close shutter, wait for settle, kick the CCD readout, wait for it to finish.
- Sits between the main command state machine and the shutter PWM and ccd_readout blocks.
- The command FSM issues one start pulse instead of timing the shutter itself over USB.

Parameters:
- TICK_DIV, 100000: clk cycles per exposure tick (1 ms at 100 MHz); must be ≥2.
- EXP_W, 24: width of the exposure length in ticks.
- SETTLE_TICKS, 300: shutter servo settle time in ticks, applied after both open and close; must be ≥1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle request; sampled only in IDLE
- abort  in  1  level; cancels an exposure in progress
- dark  in  1  sampled with start; 1 = shutter stays closed (dark frame)
- exp_ticks  in  EXP_W  exposure length; sampled with start
- readout_busy  in  1  from ccd_readout
- shutter_open  out  1  1 = open duty cycle requested
- readout_toggle  out  1  high exactly 2 cycles per readout kick
- busy  out  1  high in every state except IDLE
- done  out  1  1-cycle pulse on completion or abort
- aborted  out  1  valid with done; 1 = ended by abort, no readout issued
- state_out  out  3  current state encoding, for debug and status

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all outputs 0.
  - Latched exposure and dark registers and both counters cleared.
  - Reset during any state returns to IDLE immediately; shutter_open drops to 0 (closed).
- Timing base:
  - Prescaler counts 0..TICK_DIV-1 and restarts at 0 on every state entry.
  - A tick fires when the prescaler wraps.
  - Tick counter is cleared on every state entry.
  - A wait of N ticks occupies exactly N*TICK_DIV cycles.
- States and encodings:
  - IDLE 000: on start, latch exp_ticks and dark, go to OPEN_SETTLE. start while busy is ignored.
  - OPEN_SETTLE 001:
    - shutter_open = !dark_q.
    - After SETTLE_TICKS, go to EXPOSE, or straight to CLOSE_SETTLE if exp_q == 0.
    - In dark mode the settle time still elapses, so dark and light frames have identical timing.
  - EXPOSE 010: shutter_open = !dark_q; after exp_q ticks, go to CLOSE_SETTLE.
  - CLOSE_SETTLE 011: shutter_open = 0; after SETTLE_TICKS, go to READOUT_KICK, or to DONE if the abort flag is set.
  - READOUT_KICK 100: readout_toggle = 1 for 2 cycles, then go to READOUT_WAIT.
  - READOUT_WAIT 101:
    - Wait for readout_busy to be seen high, then low.
    - If readout_busy is never seen high within 16 cycles, treat the readout as finished.
    - Then go to DONE.
  - DONE 110: done = 1 for one cycle, then IDLE. aborted holds its value until the next start.
- Abort:
  - abort high in OPEN_SETTLE or EXPOSE: set the abort flag and go to CLOSE_SETTLE on the next cycle. The shutter always closes and settles before DONE.
  - abort in CLOSE_SETTLE: sets the flag; the remaining settle completes.
  - abort in READOUT_KICK or READOUT_WAIT is ignored, because the readout cannot be cancelled.
  - abort in IDLE is ignored.
  - abort and start in the same IDLE cycle: start wins; abort is acted on next cycle in OPEN_SETTLE.
- Counter width: the tick counter is max(EXP_W, clog2(SETTLE_TICKS+1)) bits. exp_ticks = 2^EXP_W-1 must not overflow.

Optional Feature:
- Macro: EXPOSURE_FLUSH_EN.
- Defined:
  - start first enters FLUSH_KICK (111): readout_toggle for 2 cycles, with the same wait rule as READOUT_WAIT, shutter closed.
  - Then OPEN_SETTLE.
  - An extra output, flush (1 bit), is high throughout the flush so the readout path discards that frame.
  - abort during the flush goes to DONE with aborted = 1 after the flush readout completes.
- Undefined: the flush state and the flush port do not exist; start goes directly to OPEN_SETTLE.

Decomposition:
- Shared package/header (alongside controller.vh) holds:
  - state encodings;
  - the 2-cycle toggle length;
  - the 16-cycle readout-start timeout.
- One sub-module, tick_timer:
  - prescaler plus tick counter, with a restart input, a target count input, and an expired output;
  - instantiated once and reused by every waiting state.

Test Plan:
- TICK_DIV=4, SETTLE_TICKS=2, exp_ticks=5, dark=0:
  - shutter_open rises 1 cycle after start and stays high 28 cycles (8+20).
  - readout_toggle fires 2 cycles after CLOSE_SETTLE's 8 cycles.
  - Model busy high for 10 cycles: done fires 1 cycle after busy falls; aborted=0.
- dark=1, exp_ticks=3: shutter_open stays 0 throughout; done arrives at exactly the same cycle offset as a dark=0 run with the same parameters.
- exp_ticks=0: EXPOSE is skipped; shutter_open is high for exactly 8 cycles.
- abort pulsed 6 cycles into EXPOSE:
  - shutter_open falls the next cycle;
  - 8 settle cycles follow;
  - no readout_toggle;
  - done=1 with aborted=1.
- readout_busy held 0 after the kick: done fires after the 16-cycle timeout. A start during busy is ignored (no second exposure).
- rst_n asserted mid-EXPOSE: all outputs 0 asynchronously. A start after release runs a full clean exposure (with EXPOSURE_FLUSH_EN: flush then pulses first).

Source files
------------

// File: rtl/exposure_sequencer_pkg.sv
// exposure_sequencer_pkg: state encodings and readout handshake constants
package exposure_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE         = 3'b000,
        S_OPEN_SETTLE  = 3'b001,
        S_EXPOSE       = 3'b010,
        S_CLOSE_SETTLE = 3'b011,
        S_READOUT_KICK = 3'b100,
        S_READOUT_WAIT = 3'b101,
        S_DONE         = 3'b110,
        S_FLUSH_KICK   = 3'b111
    } state_e;

    localparam int TOGGLE_LEN = 2;
    localparam int RD_TIMEOUT = 16;
    localparam int CYC_W      = 5;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exposure_sequencer_tick_timer.sv
// exposure_sequencer_tick_timer: prescaled tick counter; expired_o marks the last cycle of a target-tick wait
module exposure_sequencer_tick_timer #(
    parameter int TICK_DIV = 100000,
    parameter int CNT_W    = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] target_i,
    output logic             expired_o
);

    localparam int PRE_W = $clog2(TICK_DIV);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    always_comb begin
        tick      = pre_q == PRE_W'(TICK_DIV - 1);
        expired_o = tick && (cnt_q + CNT_W'(1) == target_i);
        pre_d     = (restart_i || tick) ? '0 : pre_q + PRE_W'(1);
        cnt_d     = restart_i ? '0 : (tick ? cnt_q + CNT_W'(1) : cnt_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exposure_sequencer.sv
// exposure_sequencer: autonomous shutter/expose/readout sequencing for one CCD frame.
// EXPOSURE_FLUSH_EN adds a flush readout (FLUSH_KICK state, flush port) before the shutter opens.
module exposure_sequencer
    import exposure_sequencer_pkg::*;
#(
    parameter int TICK_DIV     = 100000,
    parameter int EXP_W        = 24,
    parameter int SETTLE_TICKS = 300
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             dark,
    input  logic [EXP_W-1:0] exp_ticks,
    input  logic             readout_busy,
    output logic             shutter_open,
    output logic             readout_toggle,
    output logic             busy,
    output logic             done,
    output logic             aborted,
`ifdef EXPOSURE_FLUSH_EN
    output logic             flush,
`endif
    output logic [2:0]       state_out
);

    localparam int CNT_W = max_int(EXP_W, $clog2(SETTLE_TICKS + 1));

    state_e             state_q, state_d;
    logic [EXP_W-1:0]   exp_q, exp_d;
    logic               dark_q, dark_d;
    logic               abort_q, abort_d;
    logic               seen_q, seen_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [CYC_W-1:0]   wait_end;
    logic [CNT_W-1:0]   target;
    logic               expired;
    logic               restart;
    logic               rd_fin;

    exposure_sequencer_tick_timer #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .restart_i (restart),
        .target_i  (target),
        .expired_o (expired)
    );

    always_comb begin
        state_d        = state_q;
        exp_d          = exp_q;
        dark_d         = dark_q;
        abort_d        = abort_q;
        shutter_open   = 1'b0;
        readout_toggle = 1'b0;
        target         = CNT_W'(SETTLE_TICKS);
        // readout is finished once busy has been seen and dropped, or never rose before the timeout
        wait_end       = (state_q == S_FLUSH_KICK) ? CYC_W'(TOGGLE_LEN + RD_TIMEOUT - 1)
                                                   : CYC_W'(RD_TIMEOUT - 1);
        rd_fin         = !readout_busy && (seen_q || cyc_q == wait_end);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    exp_d   = exp_ticks;
                    dark_d  = dark;
                    abort_d = 1'b0;
`ifdef EXPOSURE_FLUSH_EN
                    state_d = S_FLUSH_KICK;
`else
                    state_d = S_OPEN_SETTLE;
`endif
                end
            end
            S_OPEN_SETTLE: begin
                shutter_open = !dark_q;
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_CLOSE_SETTLE;
                end else if (expired) begin
                    state_d = (exp_q == '0) ? S_CLOSE_SETTLE : S_EXPOSE;
                end
            end
            S_EXPOSE: begin
                shutter_open = !dark_q;
                target       = CNT_W'(exp_q);
                if (abort) begin
                    abort_d = 1'b1;
                    state_d = S_CLOSE_SETTLE;
                end else if (expired) begin
                    state_d = S_CLOSE_SETTLE;
                end
            end
            S_CLOSE_SETTLE: begin
                abort_d = abort_q | abort;
                if (expired) state_d = abort_d ? S_DONE : S_READOUT_KICK;
            end
            S_READOUT_KICK: begin
                readout_toggle = 1'b1;
                if (cyc_q == CYC_W'(TOGGLE_LEN - 1)) state_d = S_READOUT_WAIT;
            end
            S_READOUT_WAIT: begin
                if (rd_fin) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
`ifdef EXPOSURE_FLUSH_EN
            S_FLUSH_KICK: begin
                readout_toggle = cyc_q < CYC_W'(TOGGLE_LEN);
                abort_d        = abort_q | abort;
                if (cyc_q >= CYC_W'(TOGGLE_LEN) && rd_fin) state_d = abort_d ? S_DONE : S_OPEN_SETTLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
        restart = state_d != state_q;
        cyc_d   = restart ? '0 : ((&cyc_q) ? cyc_q : cyc_q + CYC_W'(1));
        // busy may rise during the kick itself, so the seen flag survives the KICK->WAIT hop
        seen_d  = (restart && state_d != S_READOUT_WAIT) ? 1'b0 : (seen_q | readout_busy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            exp_q   <= '0;
            dark_q  <= 1'b0;
            abort_q <= 1'b0;
            seen_q  <= 1'b0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            exp_q   <= exp_d;
            dark_q  <= dark_d;
            abort_q <= abort_d;
            seen_q  <= seen_d;
            cyc_q   <= cyc_d;
        end
    end

    assign busy      = state_q != S_IDLE;
    assign done      = state_q == S_DONE;
    assign aborted   = abort_q;
    assign state_out = state_q;
`ifdef EXPOSURE_FLUSH_EN
    assign flush     = state_q == S_FLUSH_KICK;
`endif

endmodule

// File: tb/tb_exposure_sequencer.sv
// tb_exposure_sequencer: directed exposure scenarios with TICK_DIV=4, SETTLE_TICKS=2
module tb_exposure_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dark = 1'b0;
    logic        readout_busy = 1'b0;
    logic [23:0] exp_ticks = '0;
    logic        shutter_open, readout_toggle, busy, done, aborted;
    logic [2:0]  state_out;
`ifdef EXPOSURE_FLUSH_EN
    logic        flush;
`endif

    int   n_chk = 0;
    int   n_fail = 0;
    int   sh_n, sh_first, tg_n, tg_first, done_at;
    logic ab;

    always #5 clk = ~clk;

    exposure_sequencer #(
        .TICK_DIV     (4),
        .EXP_W        (24),
        .SETTLE_TICKS (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .abort          (abort),
        .dark           (dark),
        .exp_ticks      (exp_ticks),
        .readout_busy   (readout_busy),
        .shutter_open   (shutter_open),
        .readout_toggle (readout_toggle),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
`ifdef EXPOSURE_FLUSH_EN
        .flush          (flush),
`endif
        .state_out      (state_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Cycle c is the c-th cycle after the edge that samples start; abort/start re-pulse
    // are driven after observing cycle ab_at/st_at. A busy_len>0 raises readout_busy
    // for busy_len cycles once the toggle falls.
    task automatic run(input logic [23:0] e, input logic d, input int ab_at, input int st_at,
                       input int busy_len);
        int busy_left;
        logic prev_tg;
        sh_n = 0; sh_first = 0; tg_n = 0; tg_first = 0; done_at = 0; ab = 1'b0;
        busy_left = 0;
        prev_tg = 1'b0;
        exp_ticks = e;
        dark = d;
        start = 1'b1;
        for (int c = 1; c <= 200 && done_at == 0; c++) begin
            step();
            start = 1'b0;
            abort = 1'b0;
            if (shutter_open) begin
                sh_n++;
                if (sh_first == 0) sh_first = c;
            end
            if (readout_toggle) begin
                tg_n++;
                if (tg_first == 0) tg_first = c;
            end
            if (prev_tg && !readout_toggle && busy_len > 0) busy_left = busy_len;
            prev_tg = readout_toggle;
            if (done) begin
                done_at = c;
                ab = aborted;
            end
            abort = (c == ab_at);
            start = (c == st_at);
            readout_busy = busy_left > 0;
            if (busy_left > 0) busy_left--;
        end
        start = 1'b0;
        abort = 1'b0;
        readout_busy = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_state", state_out, 0);
        chk("rst_shutter", shutter_open, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_state", state_out, 0);
        chk("idle_toggle", readout_toggle, 0);

        abort = 1'b1;
        step();
        step();
        abort = 1'b0;
        chk("idle_abort_ignored_state", state_out, 0);
        chk("idle_abort_ignored_aborted", aborted, 0);

        // light frame, exp=5, readout busy for 10 cycles
        run(24'd5, 1'b0, 0, 0, 10);
        chk("t1_shutter_first", sh_first, 1);
        chk("t1_shutter_cycles", sh_n, 28);
        chk("t1_toggle_first", tg_first, 37);
        chk("t1_toggle_cycles", tg_n, 2);
        chk("t1_done_at", done_at, 50);
        chk("t1_aborted", ab, 0);
        step();
        chk("t1_back_idle", state_out, 0);
        chk("t1_busy_low", busy, 0);
        chk("t1_done_pulse", done, 0);

        // light and dark frames with identical parameters finish at the same offset
        run(24'd3, 1'b0, 0, 0, 0);
        chk("t2l_shutter_cycles", sh_n, 20);
        chk("t2l_toggle_first", tg_first, 29);
        chk("t2l_done_at", done_at, 47);
        step();
        run(24'd3, 1'b1, 0, 0, 0);
        chk("t2d_shutter_cycles", sh_n, 0);
        chk("t2d_toggle_first", tg_first, 29);
        chk("t2d_done_at", done_at, 47);
        chk("t2d_aborted", ab, 0);
        step();

        // zero exposure skips EXPOSE
        run(24'd0, 1'b0, 0, 0, 0);
        chk("t3_shutter_cycles", sh_n, 8);
        chk("t3_toggle_first", tg_first, 17);
        chk("t3_done_at", done_at, 35);
        step();

        // abort 6 cycles into EXPOSE (EXPOSE begins at cycle 9)
        run(24'd5, 1'b0, 14, 0, 0);
        chk("t4_shutter_cycles", sh_n, 14);
        chk("t4_no_toggle", tg_n, 0);
        chk("t4_done_at", done_at, 23);
        chk("t4_aborted", ab, 1);
        step();
        chk("t4_idle", state_out, 0);
        chk("t4_aborted_held", aborted, 1);

        // busy never rises: timeout path; a start while busy is ignored
        run(24'd0, 1'b0, 0, 10, 0);
        chk("t5_shutter_cycles", sh_n, 8);
        chk("t5_done_at", done_at, 35);
        chk("t5_aborted_cleared", ab, 0);
        step();
        chk("t5_idle", busy, 0);
        step();
        step();
        chk("t5_no_second_run", busy, 0);

        // reset mid-EXPOSE drops every output asynchronously
        exp_ticks = 24'd5;
        dark = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 11; i++) step();
        chk("t6_in_expose", state_out, 2);
        chk("t6_shutter_open", shutter_open, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state_out, 0);
        chk("t6_rst_shutter", shutter_open, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_toggle", readout_toggle, 0);
        step();
        rst_n = 1'b1;
        step();
        run(24'd5, 1'b0, 0, 0, 10);
        chk("t6_rerun_shutter", sh_n, 28);
        chk("t6_rerun_toggle_first", tg_first, 37);
        chk("t6_rerun_done_at", done_at, 50);
        chk("t6_rerun_aborted", ab, 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
